fetch_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding, fetch states and the
// fetch-address legality check used by the IF stage.
package cpu_pkg;

    localparam int          ADDR_W_DEFAULT = 9;
    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // A fetch address is legal when word aligned and inside the ROM window.
    function automatic logic pc_is_legal(input logic [31:0] pc, input int addr_w);
        return (pc[1:0] == 2'b00) && ((pc >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Head is presented combinationally; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && !srst && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM,
// buffers fetched words for decode, handles redirects and fetch faults.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_data,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_pc,
    input  logic              i_ready,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_fault,
    output logic [31:0]       o_fault_pc,
    output logic [31:0]       o_retired
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  fault_pc_reg, fault_pc_next;
    logic [31:0]  retired_reg, retired_next;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic [63:0]            fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (i_clk),
        .srst      (i_reset),
        .push      (fifo_push),
        .push_data ({pc_reg, i_imem_data}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A redirect cycle neither pops nor pushes: the head being offered is stale.
    assign fifo_pop = ~fifo_empty & i_ready & ~i_redirect;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fault_pc_next = fault_pc_reg;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        retired_next  = retired_reg + (fifo_pop ? 32'd1 : 32'd0);

        if (i_redirect) begin
            fifo_flush = 1'b1;
            pc_next    = i_redirect_pc;
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (!pc_is_legal(pc_reg, ADDR_W)) begin
                        state_next    = FAULT;
                        fault_pc_next = pc_reg;
                    end else if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                        pc_next   = pc_reg + 32'd4;
                    end
                end
                default: begin
                    state_next = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            fault_pc_reg <= '0;
            retired_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fault_pc_reg <= fault_pc_next;
            retired_reg  <= retired_next;
        end
    end

    assign o_imem_addr = pc_reg[ADDR_W+1:2];
    assign o_valid     = ~fifo_empty;
    assign o_instr     = fifo_empty ? NOP_INSTR : fifo_head[31:0];
    assign o_pc        = fifo_empty ? 32'd0 : fifo_head[63:32];
    assign o_fault     = (state_reg == FAULT);
    assign o_fault_pc  = fault_pc_reg;
    assign o_retired   = retired_reg;

    // Occupancy flags must agree with the entry count.
    a_full_count: assert property (@(posedge i_clk) disable iff (i_reset)
        fifo_full == (fifo_count == ($clog2(DEPTH) + 1)'(DEPTH)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a queue-based reference
// of the decode-visible instruction stream is compared on every cycle.
module tb_fetch_sequencer;

    localparam int          ADDR_W    = 9;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] ROM_BYTES = 32'h0000_0800;

    logic        clk;
    logic        reset;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retired;

    logic [31:0] rom [512];

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc          (pc),
        .i_ready       (ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_fault       (fault),
        .o_fault_pc    (fault_pc),
        .o_retired     (retired)
    );

    assign imem_data = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      sb_q[$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;
    logic [31:0] m_retired;
    bit          pop_flag;
    bit          armed;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode sees addresses sequential from the last reset/redirect,
    // fetch stops at the first illegal address, buffer never exceeds DEPTH.
    initial begin
        armed    = 0;
        pop_flag = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                sb_q.delete();
                m_pc       = 32'h0;
                m_fault    = 0;
                m_fault_pc = 32'h0;
                m_retired  = 32'h0;
            end else begin
                if (pop_flag) m_retired = m_retired + 32'd1;
                if (redirect) begin
                    sb_q.delete();
                    m_pc    = redirect_pc;
                    m_fault = 0;
                end else if (!m_fault) begin
                    if ((m_pc % 4) != 0 || m_pc >= ROM_BYTES) begin
                        m_fault    = 1;
                        m_fault_pc = m_pc;
                    end else if (sb_q.size() < DEPTH) begin
                        sb_q.push_back('{m_pc, rom[m_pc / 4]});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            pop_flag = 0;
            armed    = 1;
        end
    end

    // Monitor: compare DUT outputs with the reference mid-cycle, retire on handshake.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("valid", {31'd0, valid}, {31'd0, sb_q.size() > 0});
                if (sb_q.size() > 0) begin
                    chk("head_pc", pc, sb_q[0].pc);
                    chk("head_instr", instr, sb_q[0].instr);
                end else begin
                    chk("empty_pc", pc, 32'h0);
                    chk("empty_instr", instr, 32'h0);
                end
                chk("fault", {31'd0, fault}, {31'd0, m_fault});
                chk("fault_pc", fault_pc, m_fault_pc);
                chk("retired", retired, m_retired);
                chk("imem_addr", {23'd0, imem_addr}, (m_pc >> 2) & 32'h1FF);
                if (sb_q.size() > 0 && ready && !redirect && !reset) begin
                    e = sb_q.pop_front();
                    pop_flag = 1;
                    $display("pop pc=%h instr=%h retired=%0d", e.pc, e.instr, m_retired + 1);
                end
            end
        end
    end

    task automatic drive(input bit r, input bit rd, input logic [31:0] t, input bit rs, input int n);
        for (int k = 0; k < n; k++) begin
            ready       = r;
            redirect    = rd;
            redirect_pc = t;
            reset       = rs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        rom[0]  = 32'h2010_0000;
        rom[65] = 32'h23bd_fffc;
        ready = 1; redirect = 0; redirect_pc = 0; reset = 1;

        drive(1, 0, 0, 1, 2);          // reset
        drive(1, 0, 0, 0, 6);          // streaming from reset
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 5);          // stall: buffer fills, pc holds
        drive(1, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 3);          // fill, then redirect while full
        drive(0, 1, 32'h104, 0, 1);
        drive(0, 0, 0, 0, 3);
        drive(1, 0, 0, 0, 3);
        drive(1, 1, 32'h802, 0, 1);    // misaligned target faults
        drive(1, 0, 0, 0, 4);
        drive(1, 1, 32'h0, 0, 1);      // recovery
        drive(1, 0, 0, 0, 4);
        drive(1, 1, 32'h7F0, 0, 1);    // run off the ROM end
        drive(1, 0, 0, 0, 8);
        drive(0, 1, 32'h0, 0, 1);
        drive(0, 0, 0, 0, 3);
        drive(1, 1, 32'h104, 1, 1);    // reset wins over redirect while full
        drive(0, 0, 0, 0, 2);
        drive(1, 0, 0, 0, 3);

        for (int c = 0; c < 3000; c++) begin
            tgt = 32'h0;
            if ($urandom_range(0, 99) < 6) begin
                case ($urandom_range(0, 3))
                    0: tgt = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
                    1: tgt = 32'h7F0 + 32'($urandom_range(0, 3)) * 4;
                    2: tgt = $urandom;
                    default: tgt = 32'($urandom_range(0, 15)) * 4;
                endcase
                drive($urandom_range(0, 3) != 0, 1, tgt, $urandom_range(0, 99) < 3, 1);
            end else begin
                drive($urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 99) < 1, 1);
            end
        end
        drive(1, 0, 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
